// File: rtl/fpu_ss_offload_buffer.sv
// fpu_ss_offload_buffer: completes the core offload handshake and queues accepted instructions with operands
module fpu_ss_offload_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int ID_W  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_instr_i,
  input  logic [ID_W-1:0]            in_id_i,
  input  logic [XLEN-1:0]            in_rs1_i,
  input  logic [XLEN-1:0]            in_rs2_i,
  input  logic [XLEN-1:0]            in_rs3_i,
  input  logic [2:0]                 in_rs_valid_i,
  input  logic                       prd_accept_i,
  input  logic                       prd_writeback_i,
  input  logic                       prd_is_mem_op_i,
  input  logic [2:0]                 prd_use_rs_i,
  output logic                       issue_accept_o,
  output logic                       issue_writeback_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_instr_o,
  output logic [ID_W-1:0]            out_id_o,
  output logic [XLEN-1:0]            out_rs1_o,
  output logic [XLEN-1:0]            out_rs2_o,
  output logic [XLEN-1:0]            out_rs3_o,
  output logic                       out_writeback_o,
  output logic                       out_is_mem_op_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]     instr_q [DEPTH];
  logic [ID_W-1:0] id_q    [DEPTH];
  logic [XLEN-1:0] rs1_q   [DEPTH];
  logic [XLEN-1:0] rs2_q   [DEPTH];
  logic [XLEN-1:0] rs3_q   [DEPTH];
  logic [DEPTH-1:0] wb_q, mem_q;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic            rs_ok, push, pop;
  always_comb begin
    rs_ok             = &(~prd_use_rs_i | in_rs_valid_i);
    in_ready_o        = flush_i ? 1'b0 : !prd_accept_i ? 1'b1 : (count_q < CW'(DEPTH)) & rs_ok;
    issue_accept_o    = prd_accept_i;
    issue_writeback_o = prd_accept_i & prd_writeback_i;
    out_valid_o       = count_q != '0;
    push              = in_valid_i & in_ready_o & prd_accept_i;
    pop               = out_valid_o & out_ready_i;
  end
  assign out_instr_o     = instr_q[rd_ptr];
  assign out_id_o        = id_q[rd_ptr];
  assign out_rs1_o       = rs1_q[rd_ptr];
  assign out_rs2_o       = rs2_q[rd_ptr];
  assign out_rs3_o       = rs3_q[rd_ptr];
  assign out_writeback_o = wb_q[rd_ptr];
  assign out_is_mem_op_o = mem_q[rd_ptr];
  assign count_o         = count_q;
  // flush only rewinds pointers; stale storage is unreachable until overwritten
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      wb_q    <= '0;
      mem_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        id_q[i]    <= '0;
        rs1_q[i]   <= '0;
        rs2_q[i]   <= '0;
        rs3_q[i]   <= '0;
      end
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= in_instr_i;
        id_q[wr_ptr]    <= in_id_i;
        rs1_q[wr_ptr]   <= prd_use_rs_i[0] ? in_rs1_i : '0;
        rs2_q[wr_ptr]   <= prd_use_rs_i[1] ? in_rs2_i : '0;
        rs3_q[wr_ptr]   <= prd_use_rs_i[2] ? in_rs3_i : '0;
        wb_q[wr_ptr]    <= prd_writeback_i;
        mem_q[wr_ptr]   <= prd_is_mem_op_i;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_fpu_ss_offload_buffer.sv
// tb_fpu_ss_offload_buffer: scoreboard bench with a queue-based reference model of the offload buffer
module tb_fpu_ss_offload_buffer;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int ID_W  = 4;
  logic clk = 0, rst_ni = 0, flush_i = 0, in_valid_i = 0, out_ready_i = 0;
  logic [31:0] in_instr_i = 0;
  logic [ID_W-1:0] in_id_i = 0;
  logic [XLEN-1:0] in_rs1_i = 0, in_rs2_i = 0, in_rs3_i = 0;
  logic [2:0] in_rs_valid_i = 0, prd_use_rs_i = 0;
  logic prd_accept_i = 0, prd_writeback_i = 0, prd_is_mem_op_i = 0;
  logic in_ready_o, issue_accept_o, issue_writeback_o, out_valid_o, out_writeback_o, out_is_mem_op_o;
  logic [31:0] out_instr_o;
  logic [ID_W-1:0] out_id_o;
  logic [XLEN-1:0] out_rs1_o, out_rs2_o, out_rs3_o;
  logic [$clog2(DEPTH):0] count_o;
  int total = 0, bad = 0;

  typedef struct {
    logic [31:0] instr; logic [ID_W-1:0] id;
    logic [XLEN-1:0] rs1, rs2, rs3; logic wb, mem;
  } ent_t;
  ent_t q[$];
  ent_t e;
  logic held = 0;
  logic [159:0] prev_out;

  always #5 clk = ~clk;

  fpu_ss_offload_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .ID_W(ID_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_instr_i(in_instr_i), .in_id_i(in_id_i),
    .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rs3_i(in_rs3_i), .in_rs_valid_i(in_rs_valid_i),
    .prd_accept_i(prd_accept_i), .prd_writeback_i(prd_writeback_i),
    .prd_is_mem_op_i(prd_is_mem_op_i), .prd_use_rs_i(prd_use_rs_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_instr_o(out_instr_o), .out_id_o(out_id_o),
    .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o), .out_rs3_o(out_rs3_o),
    .out_writeback_o(out_writeback_o), .out_is_mem_op_o(out_is_mem_op_o), .count_o(count_o)
  );

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [159:0] dut_head();
    return {out_instr_o, out_id_o, out_rs1_o, out_rs2_o, out_rs3_o, out_writeback_o, out_is_mem_op_o};
  endfunction

  // reference model: a plain queue, with readiness derived from its size
  always @(negedge clk) begin
    if (!rst_ni) begin
      q.delete();
      held = 0;
      chk("rst_count", count_o, 0);
      chk("rst_valid", out_valid_o, 0);
    end else begin
      logic rs_ok, exp_ready;
      rs_ok = &(~prd_use_rs_i | in_rs_valid_i);
      exp_ready = flush_i ? 1'b0 : !prd_accept_i ? 1'b1 : (q.size() < DEPTH) && rs_ok;
      chk("in_ready", in_ready_o, exp_ready);
      chk("issue_accept", issue_accept_o, prd_accept_i);
      chk("issue_writeback", issue_writeback_o, prd_accept_i & prd_writeback_i);
      chk("count", count_o, q.size());
      chk("count_le_depth", count_o <= DEPTH, 1);
      chk("out_valid", out_valid_o, q.size() != 0);
      if (held) chk("head_stable", dut_head(), prev_out);
      held = out_valid_o & ~out_ready_i & ~flush_i;
      prev_out = dut_head();
      if (flush_i) q.delete();
      else begin
        if (out_valid_o && out_ready_i) begin
          if (q.size() == 0) chk("pop_when_empty", 1, 0);
          else begin
            e = q.pop_front();
            chk("head", dut_head(), {e.instr, e.id, e.rs1, e.rs2, e.rs3, e.wb, e.mem});
          end
        end
        if (in_valid_i && in_ready_o && prd_accept_i) begin
          if (q.size() >= DEPTH) chk("push_when_full", 1, 0);
          e.instr = in_instr_i; e.id = in_id_i;
          e.rs1 = prd_use_rs_i[0] ? in_rs1_i : 0;
          e.rs2 = prd_use_rs_i[1] ? in_rs2_i : 0;
          e.rs3 = prd_use_rs_i[2] ? in_rs3_i : 0;
          e.wb = prd_writeback_i; e.mem = prd_is_mem_op_i;
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [ID_W-1:0] id, input logic acc,
                       input logic [2:0] use_rs, input logic [2:0] rsv, input logic [31:0] rs1);
    in_valid_i = 1; in_instr_i = instr; in_id_i = id; prd_accept_i = acc;
    prd_writeback_i = 1; prd_is_mem_op_i = 0; prd_use_rs_i = use_rs; in_rs_valid_i = rsv;
    in_rs1_i = rs1; in_rs2_i = $urandom; in_rs3_i = $urandom;
  endtask

  task automatic idle();
    in_valid_i = 0; prd_accept_i = 0; flush_i = 0; out_ready_i = 0;
  endtask

  task automatic drain();
    out_ready_i = 1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    out_ready_i = 0;
  endtask

  initial begin
    #2;
    chk("rst_out_instr", out_instr_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    tick(); tick();
    rst_ni = 1;
    tick();
    // FADD.S with no scalar operands
    offer(32'h00208053, 3, 1, 3'b000, 3'b000, 32'hDEADBEEF);
    #1;
    chk("fadd_in_ready", in_ready_o, 1);
    chk("fadd_issue_accept", issue_accept_o, 1);
    tick(); idle(); #1;
    chk("fadd_valid", out_valid_o, 1);
    chk("fadd_instr", out_instr_o, 32'h00208053);
    chk("fadd_id", out_id_o, 3);
    chk("fadd_rs1_masked", out_rs1_o, 0);
    chk("fadd_count", count_o, 1);
    drain();
    // rejected ADDI
    offer(32'h00000013, 5, 0, 3'b000, 3'b000, 0);
    #1;
    chk("addi_in_ready", in_ready_o, 1);
    chk("addi_issue_accept", issue_accept_o, 0);
    tick(); idle(); #1;
    chk("addi_count", count_o, 0);
    chk("addi_valid", out_valid_o, 0);
    // FCVT.S.W waits for rs1
    offer(32'hD0050053, 7, 1, 3'b001, 3'b000, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("fcvt_wait_ready", in_ready_o, 0);
      tick();
    end
    in_rs_valid_i = 3'b001; in_rs1_i = 32'h2A;
    #1 chk("fcvt_ready", in_ready_o, 1);
    tick(); idle(); #1;
    chk("fcvt_rs1", out_rs1_o, 32'h2A);
    drain();
    // fill, overflow attempt, pop one
    for (int i = 0; i < DEPTH; i++) begin
      offer(32'h00208053, ID_W'(i), 1, 3'b000, 3'b000, 0);
      tick();
    end
    idle(); #1;
    chk("fill_count", count_o, DEPTH);
    offer(32'h00208053, 9, 1, 3'b000, 3'b000, 0);
    #1 chk("full_in_ready", in_ready_o, 0);
    out_ready_i = 1;
    tick();
    out_ready_i = 0; #1;
    chk("after_pop_ready", in_ready_o, 1);
    in_valid_i = 0;
    drain();
    // simultaneous push and pop at count 2
    for (int i = 0; i < 2; i++) begin
      offer($urandom, ID_W'(i + 4), 1, 3'b111, 3'b111, $urandom);
      tick();
    end
    offer($urandom, 6, 1, 3'b010, 3'b010, $urandom);
    out_ready_i = 1;
    tick(); idle(); #1;
    chk("pushpop_count", count_o, 2);
    drain();
    // flush with 3 queued and a concurrent offer
    for (int i = 0; i < 3; i++) begin
      offer($urandom, ID_W'(i), 1, 3'b000, 3'b000, 0);
      tick();
    end
    offer($urandom, 8, 1, 3'b000, 3'b000, 0);
    flush_i = 1; out_ready_i = 1;
    tick(); idle(); #1;
    chk("flush_count", count_o, 0);
    chk("flush_valid", out_valid_o, 0);
    // randomized traffic with one asynchronous reset mid-stream
    for (int c = 0; c < 3000; c++) begin
      in_valid_i = $urandom_range(0, 3) != 0;
      in_instr_i = $urandom; in_id_i = ID_W'($urandom);
      in_rs1_i = $urandom; in_rs2_i = $urandom; in_rs3_i = $urandom;
      prd_accept_i = $urandom_range(0, 4) != 0;
      prd_writeback_i = 1'($urandom); prd_is_mem_op_i = 1'($urandom);
      prd_use_rs_i = 3'($urandom); in_rs_valid_i = 3'($urandom) | 3'($urandom);
      out_ready_i = $urandom_range(0, 2) == 0;
      flush_i = $urandom_range(0, 40) == 0;
      if (c == 1500) begin
        #2 rst_ni = 0;
        #1;
        chk("async_rst_valid", out_valid_o, 0);
        chk("async_rst_count", count_o, 0);
        chk("async_rst_instr", out_instr_o, 0);
        @(posedge clk); #1 rst_ni = 1;
      end
      tick();
    end
    idle();
    drain();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
